// File: rtl/paicore_rx_pkg.sv
// Shared constants, types and helpers for the PAICORE receive channel.
package paicore_rx_pkg;

  localparam int WORD_WIDTH  = 32;
  localparam int FRAME_WIDTH = 64;

  typedef enum logic {
    IDLE  = 1'b0,
    ACKED = 1'b1
  } rx_state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/paicore_rx_fifo.sv
// First-word-fall-through frame FIFO with a registered full flag and an
// AXI-Stream style read side.
module paicore_rx_fifo
  import paicore_rx_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  full,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid
);

  localparam int ADDR_WIDTH = clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   COUNT_ONE  = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH:0]   count_next;
  logic                  do_push;
  logic                  do_pop;

  assign do_push       = push && !full;
  assign do_pop        = m_axis_tvalid && m_axis_tready;
  assign m_axis_tvalid = (count != '0);
  // Masking keeps tdata at zero whenever nothing is stored, including after reset.
  assign m_axis_tdata  = m_axis_tvalid ? mem[rd_ptr] : '0;

  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + COUNT_ONE;
      2'b01:   count_next = count - COUNT_ONE;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count <= count_next;
      full  <= (count_next == FULL_COUNT);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/paicore_rx_channel.sv
// One PAICORE output-link channel: 4-phase word receiver that pairs words into
// 64-bit frames and streams them out through a small FIFO.
module paicore_rx_channel
  import paicore_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH       = 4,
  parameter int DATA_WIDTH  = 64
) (
  input  logic                  m_axis_aclk,
  input  logic                  m_axis_aresetn,
  input  logic                  request,
  input  logic [31:0]           din,
  output logic                  acknowledge,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  output logic                  o_half_pending,
  output logic [31:0]           o_frame_cnt
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_in;
  logic                   req_s;

  rx_state_t             state_q;
  rx_state_t             state_d;
  logic                  ack_q;
  logic                  ack_d;
  logic                  phase_q;
  logic                  phase_d;
  logic [WORD_WIDTH-1:0] hold_q;
  logic [WORD_WIDTH-1:0] hold_d;
  logic [31:0]           frame_cnt_q;
  logic [31:0]           frame_cnt_d;
  logic                  fifo_push;
  logic [DATA_WIDTH-1:0] fifo_din;
  logic                  fifo_full;
  logic                  can_take;

  assign sync_in = {sync_q[SYNC_STAGES-2:0], request};
  assign req_s   = sync_q[SYNC_STAGES-1];

  for (genvar i = 0; i < SYNC_STAGES; i++) begin : g_sync
    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
      if (!m_axis_aresetn) sync_q[i] <= 1'b0;
      else                 sync_q[i] <= sync_in[i];
    end
  end

  // A first half only needs the hold register, so it is taken even when the FIFO is full.
  assign can_take = !phase_q || !fifo_full;

  always_comb begin
    state_d     = state_q;
    ack_d       = ack_q;
    phase_d     = phase_q;
    hold_d      = hold_q;
    frame_cnt_d = frame_cnt_q;
    fifo_push   = 1'b0;
    fifo_din    = {hold_q, din};
    case (state_q)
      IDLE: begin
        if (req_s && can_take) begin
          state_d = ACKED;
          ack_d   = 1'b1;
          if (!phase_q) begin
            hold_d  = din;
            phase_d = 1'b1;
          end else begin
            fifo_push   = 1'b1;
            phase_d     = 1'b0;
            frame_cnt_d = frame_cnt_q + 32'd1;
          end
        end
      end
      ACKED: begin
        if (!req_s) begin
          state_d = IDLE;
          ack_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        ack_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      state_q     <= IDLE;
      ack_q       <= 1'b0;
      phase_q     <= 1'b0;
      hold_q      <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      phase_q     <= phase_d;
      hold_q      <= hold_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  paicore_rx_fifo #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk           (m_axis_aclk),
    .rst_n         (m_axis_aresetn),
    .push          (fifo_push),
    .din           (fifo_din),
    .full          (fifo_full),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid)
  );

  assign acknowledge    = ack_q;
  assign m_axis_tlast   = 1'b0;
  assign o_half_pending = phase_q;
  assign o_frame_cnt    = frame_cnt_q;

endmodule

// File: doc/paicore_rx_channel.md
Name: paicore_rx_channel

Overview:
- Single-channel receiver on the PAICORE output link, one instance per channel, upstream of the multi-channel join/arbiter stage.
- Takes the chip's asynchronous 4-phase request/acknowledge link carrying 32-bit words and pairs consecutive words into 64-bit frames.
- Buffers frames in a small FIFO and presents them on an AXI-Stream master with full backpressure, so no word is ever lost.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on request; legal range 2..4.
- DEPTH, 4, FIFO depth in 64-bit frames; power of two, at least 2.
- DATA_WIDTH, 64, frame width; fixed at 2×32.

Ports:
- m_axis_aclk  in  1  sole clock.
- m_axis_aresetn  in  1  reset; asynchronous assert, active-low.
- request  in  1  chip request, asynchronous to m_axis_aclk.
- din  in  32  chip word; stable while request is high.
- acknowledge  out  1  4-phase acknowledge to the chip.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  64  frame; first word received in [63:32], second in [31:0].
- m_axis_tlast  out  1  tied 0.
- m_axis_tvalid  out  1  FIFO not empty.
- o_half_pending  out  1  first half held, waiting for the second.
- o_frame_cnt  out  32  frames pushed since reset; wraps 0xFFFFFFFF→0.

Behaviour:
- Reset (async, aresetn=0): acknowledge=0, state=IDLE, phase=0, FIFO empty, tvalid=0, tdata=0 (memory need not clear; output is masked), o_half_pending=0, o_frame_cnt=0. Reset mid-handshake drops acknowledge immediately; the chip retries the word and the partial half is discarded.
- req_s is request after SYNC_STAGES flops, all reset to 0. din is sampled only when req_s=1, which is safe under the 4-phase protocol.
- can_take = (phase==0) || !full. full is registered, count==DEPTH.
- FSM IDLE:
  - If req_s && can_take: capture din, acknowledge←1, go to ACKED.
  - phase 0: hold register←din, phase←1.
  - phase 1: push {hold,din} to the FIFO, phase←0, o_frame_cnt++.
- FSM ACKED: when req_s==0, acknowledge←0, go to IDLE. Request stays high until this happens.
- Latency:
  - request rise → acknowledge rise: SYNC_STAGES+1 edges.
  - request fall → acknowledge fall: SYNC_STAGES+1 edges.
  - Second-half capture edge → m_axis_tvalid=1 in the next cycle, i.e. first-word fall-through with a registered write.
- Backpressure: when full and phase==1, acknowledge is withheld and the chip stalls. A first half is always accepted.
- FIFO: pop on tvalid&&tready.
  - Simultaneous push and pop leaves count unchanged.
  - A pop in the same cycle does not unblock a push when full (full is registered).
  - Pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
- AXIS rule: while tvalid=1 and tready=0, tdata and tvalid stay stable.
- o_half_pending = phase.

Decomposition:
- Package paicore_rx_pkg:
  - WORD_WIDTH=32, FRAME_WIDTH=64.
  - rx_state_t enum {IDLE, ACKED}.
  - clog2 helper, if not already provided by the shared package.
- Sub-module paicore_rx_fifo: synchronous FWFT FIFO with DEPTH and DATA_WIDTH parameters. Ports: push, din, full, plus AXIS m-side.
- The synchronizer is inline, a generate loop of flops.

Test Plan:
- Reset, then send words 0xAAAA0001 and 0xBBBB0002, tready=1 → one beat with tdata=0xAAAA0001BBBB0002; o_frame_cnt=1; each acknowledge rise occurs SYNC_STAGES+1 edges after its request rise.
- Send 3 words → one frame out, o_half_pending=1 holding the third word; a 4th word completes frame 2, with the third word in [63:32].
- tready=0, send 10 words → FIFO holds 4 frames; the 9th word is acknowledged (first half), the 10th is not acknowledged while request stays high; raise tready → 10th acknowledged, 5 frames drain in order, none lost.
- Full FIFO, tready pulsed for 1 cycle while the 10th word is pending → exactly one pop; the push happens on a later edge, never the same edge.
- Assert aresetn=0 while acknowledge=1 with one half pending → acknowledge, tvalid and o_half_pending go 0 immediately (asynchronously); after release, a new 2-word handshake produces a correct frame.
- Preload o_frame_cnt by forcing it to 0xFFFFFFFF, push one frame → counter reads 0x00000000.
